// File: rtl/mitchell_pkg.sv
// Shared constants, stage-register layouts and log/antilog helpers for the Mitchell multiplier.
// Datapath fields are sized for the widest legal operand and kept left-aligned.
package mitchell_pkg;

  localparam int NUM_STAGES = 3;
  localparam int MAX_W      = 32;
  localparam int MAX_LW     = 5;
  localparam int L_W        = MAX_LW + MAX_W;

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic              zero;
    logic [MAX_LW-1:0] kx;
    logic [MAX_LW-1:0] ky;
    logic [MAX_W-2:0]  fx;
    logic [MAX_W-2:0]  fy;
  } s1_t;

  typedef struct packed {
    logic           valid;
    logic           sign;
    logic           zero;
    logic [L_W-1:0] l;
  } s2_t;

  // Mantissa bits below the leading one, left-aligned to the MAX_W-1 fraction field.
  function automatic logic [MAX_W-2:0] norm_frac(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_LW-1:0] k);
    return (MAX_W-1)'(a << (MAX_LW'(MAX_W-1) - k));
  endfunction

  // Left alignment of the fraction makes the truncating right shift identical to the narrow form.
  function automatic logic [2*MAX_W-1:0] antilog(input logic [L_W-1:0] l);
    logic [MAX_LW:0]  k;
    logic [MAX_W-1:0] m;
    k = l[L_W-1:MAX_W-1];
    m = {1'b1, l[MAX_W-2:0]};
    if (k >= (MAX_LW+1)'(MAX_W-1))
      return (2*MAX_W)'(m) << (k - (MAX_LW+1)'(MAX_W-1));
    else
      return (2*MAX_W)'(m >> ((MAX_LW+1)'(MAX_W-1) - k));
  endfunction

endpackage

// File: rtl/lod_enc.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
module lod_enc #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  output logic [LW-1:0]    k,
  output logic             zero
);

  always_comb begin
    // NOTE: every output gets a value before the loop, so no latch is inferred.
    k    = '0;
    zero = ~|a;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) k = LW'(i);
    end
  end

endmodule

// File: rtl/mitchell_mul_pipe.sv
// Three-stage Mitchell logarithmic multiplier: normalise, add logs, antilog with sign/zero fix-up.
// A single advance enable stalls the whole pipe while the output is held.
module mitchell_mul_pipe
  import mitchell_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] p_o
);

  // The register chain below is written out for exactly NUM_STAGES stages.
  if (WIDTH < 4 || WIDTH > MAX_W || NUM_STAGES != 3) begin : g_bad_cfg
    $error("mitchell_mul_pipe: unsupported WIDTH %0d", WIDTH);
  end

  logic               en;
  logic               sign;
  logic [WIDTH-1:0]   mag_x;
  logic [WIDTH-1:0]   mag_y;
  logic [LW-1:0]      kx;
  logic [LW-1:0]      ky;
  logic               zero_x;
  logic               zero_y;
  s1_t                s1_d;
  s1_t                s1_q;
  s2_t                s2_q;
  logic [2*WIDTH-1:0] mag_p;
  logic [2*WIDTH-1:0] p_d;

  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  assign sign  = signed_i & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
  assign mag_x = (signed_i && x_i[WIDTH-1]) ? -x_i : x_i;
  assign mag_y = (signed_i && y_i[WIDTH-1]) ? -y_i : y_i;

  lod_enc #(.WIDTH(WIDTH), .LW(LW)) u_lod_x (.a(mag_x), .k(kx), .zero(zero_x));
  lod_enc #(.WIDTH(WIDTH), .LW(LW)) u_lod_y (.a(mag_y), .k(ky), .zero(zero_y));

  always_comb begin
    s1_d.valid = valid_i;
    s1_d.sign  = sign;
    s1_d.zero  = zero_x | zero_y;
    s1_d.kx    = MAX_LW'(kx);
    s1_d.ky    = MAX_LW'(ky);
    s1_d.fx    = norm_frac(MAX_W'(mag_x), MAX_LW'(kx));
    s1_d.fy    = norm_frac(MAX_W'(mag_y), MAX_LW'(ky));
  end

  assign mag_p = (2*WIDTH)'(antilog(s2_q.l));
  assign p_d   = s2_q.zero ? '0 : (s2_q.sign ? -mag_p : mag_p);

  // NOTE: datapath registers are reset too, so p_o is a defined zero straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= '0;
      s2_q    <= '0;
      valid_o <= 1'b0;
      p_o     <= '0;
    end else if (en) begin
      // NOTE: non-blocking updates let every stage read its predecessor's pre-edge value.
      s1_q       <= s1_d;
      s2_q.valid <= s1_q.valid;
      s2_q.sign  <= s1_q.sign;
      s2_q.zero  <= s1_q.zero;
      s2_q.l     <= L_W'({s1_q.kx, s1_q.fx}) + L_W'({s1_q.ky, s1_q.fy});
      valid_o    <= s2_q.valid;
      p_o        <= p_d;
    end
  end

endmodule
